instruction_fetch_queue: RTL and testbench

//  Parametrised front end of the mspu core: holds the PC and an embedded word-addressed IMEM.

---
 rtl/instruction_fetch_queue.sv | 132 +++++++++++++
 tb/tb_instruction_fetch_queue.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch front end: PC, embedded word-addressed IMEM with a host write port,
// and a QDEPTH-entry prefetch queue that decode drains through valid/ready.
module instruction_fetch_queue #(
    parameter int               XLEN       = 32,
    parameter logic [XLEN-1:0]  START_ADDR = 32'h8000_0000,
    parameter int               IMEM_AW    = 12,
    parameter int               QDEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      run,
    input  logic [XLEN-1:0]           insn_addr,
    input  logic [XLEN-1:0]           insn_din,
    input  logic                      insn_we,
    input  logic [XLEN-1:0]           pc_in,
    input  logic                      pc_in_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_pc,
    output logic [XLEN-1:0]           out_insn,
    output logic [$clog2(QDEPTH):0]   q_count
);
    localparam int PW    = $clog2(QDEPTH);
    localparam int CW    = PW + 1;
    localparam int DEPTH = 1 << IMEM_AW;
    localparam logic [CW:0]   QLIM  = QDEPTH[CW:0];
    localparam logic [CW-1:0] QFULL = QDEPTH[CW-1:0];

    logic [XLEN-1:0] mem [DEPTH];
    logic [XLEN-1:0] imem_q;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rd_pc_q, rd_pc_d;
    logic            rd_pending_q, rd_pending_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] qpc_q   [QDEPTH];
    logic [XLEN-1:0] qinsn_q [QDEPTH];

    logic        pop, push, flush, issue;
    logic [CW:0] occ;

    assign out_valid = (count_q != '0);
    assign out_pc    = qpc_q[head_q];
    assign out_insn  = qinsn_q[head_q];
    assign q_count   = count_q;

    assign pop   = out_valid & out_ready;
    assign flush = ~run | pc_in_en;
    // A read already in flight owns a slot, so it is counted against the queue limit.
    assign push  = rd_pending_q & ~flush;
    assign occ   = {1'b0, count_q} + {{CW{1'b0}}, rd_pending_q} - {{CW{1'b0}}, pop};
    assign issue = run & ~pc_in_en & (occ < QLIM);

    logic unused_addr_bits;
    assign unused_addr_bits = ^{insn_addr[XLEN-1:IMEM_AW+2], insn_addr[1:0]};

    // Sync-read RAM; a same-word write in the read cycle yields the old word.
    always_ff @(posedge clk) begin
        if (insn_we) begin
            mem[insn_addr[IMEM_AW+1:2]] <= insn_din;
        end
        if (issue) begin
            imem_q <= mem[pc_q[IMEM_AW+1:2]];
        end
    end

    always_comb begin
        pc_d         = pc_q;
        rd_pc_d      = rd_pc_q;
        rd_pending_d = 1'b0;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        if (!run) begin
            pc_d = START_ADDR;
        end else if (pc_in_en) begin
            pc_d = pc_in;
        end else if (issue) begin
            rd_pc_d      = pc_q;
            rd_pending_d = 1'b1;
            pc_d         = pc_q + XLEN'(4);
        end
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PW'(1);
            if (pop)  head_d = head_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= START_ADDR;
            rd_pc_q      <= '0;
            rd_pending_q <= 1'b0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
        end else begin
            pc_q         <= pc_d;
            rd_pc_q      <= rd_pc_d;
            rd_pending_q <= rd_pending_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < QDEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    qpc_q[gi]   <= '0;
                    qinsn_q[gi] <= '0;
                end else if (push && (tail_q == PW'(gi))) begin
                    qpc_q[gi]   <= rd_pc_q;
                    qinsn_q[gi] <= imem_q;
                end
            end
        end
    endgenerate

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && (count_q == QFULL)));

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: directed scenarios plus random traffic, with a
// negedge monitor comparing every accepted instruction against a sequential-stream model.
module tb_instruction_fetch_queue;
    localparam logic [31:0] START = 32'h8000_0000;
    localparam int QD = 4;
    localparam int AW = 12;

    logic        clk = 1'b0;
    logic        reset, run, insn_we, pc_in_en, out_ready;
    logic [31:0] insn_addr, insn_din, pc_in;
    logic        out_valid;
    logic [31:0] out_pc, out_insn;
    logic [2:0]  q_count;

    instruction_fetch_queue #(.XLEN(32), .START_ADDR(START), .IMEM_AW(AW), .QDEPTH(QD)) dut (
        .clk(clk), .reset(reset), .run(run),
        .insn_addr(insn_addr), .insn_din(insn_din), .insn_we(insn_we),
        .pc_in(pc_in), .pc_in_en(pc_in_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_insn(out_insn), .q_count(q_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pops  = 0;

    logic [31:0] model_mem [1 << AW];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] next_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: accepted instructions form a sequential stream from the latest restart point.
    function automatic void restart(input logic [31:0] a);
        exp_q.delete();
        next_pc = a;
    endfunction

    function automatic void top_up();
        exp_t e;
        while (exp_q.size() < 8) begin
            e.pc   = next_pc;
            e.insn = model_mem[next_pc[AW+1:2]];
            exp_q.push_back(e);
            next_pc = next_pc + 32'd4;
        end
    endfunction

    logic        prev_stall = 1'b0;
    logic [31:0] prev_pc, prev_insn;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            restart(START);
            top_up();
            prev_stall = 1'b0;
        end else begin
            n_tests++;
            if (q_count > 3'(QD) || out_valid != (q_count != 3'd0)) begin
                n_fail++;
                $display("FAIL mon_count: got q_count %0d valid %0b required <=%0d and consistent",
                         q_count, out_valid, QD);
            end
            if (prev_stall) begin
                chk("mon_stall_valid", 32'(out_valid), 32'd1);
                chk("mon_stall_pc", out_pc, prev_pc);
                chk("mon_stall_insn", out_insn, prev_insn);
            end
            if (out_valid && out_ready) begin
                top_up();
                e = exp_q.pop_front();
                chk("mon_pc", out_pc, e.pc);
                chk("mon_insn", out_insn, e.insn);
                n_pops++;
            end
            prev_stall = out_valid && !out_ready && run && !pc_in_en;
            prev_pc    = out_pc;
            prev_insn  = out_insn;
            if (!run) restart(START);
            else if (pc_in_en) restart(pc_in);
            top_up();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pops0;
        logic [31:0] d, a;
        reset = 1'b1; run = 1'b0; insn_we = 1'b0; pc_in_en = 1'b0; out_ready = 1'b0;
        insn_addr = '0; insn_din = '0; pc_in = '0;
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(q_count), 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_insn", out_insn, 32'd0);
        tick();
        reset = 1'b0;

        for (int i = 0; i < (1 << AW); i++) begin
            d = (i < 8) ? 32'h100 + 32'(i) : $urandom;
            model_mem[i] = d;
            insn_we = 1'b1; insn_addr = START + 32'(4 * i); insn_din = d;
            tick();
        end
        insn_we = 1'b0;

        // 1: sequential stream after run rises
        out_ready = 1'b1; run = 1'b1;
        tick();
        chk("t1_not_yet", 32'(out_valid), 32'd0);
        tick();
        chk("t1_first_valid", 32'(out_valid), 32'd1);
        chk("t1_first_pc", out_pc, START);
        chk("t1_first_insn", out_insn, 32'h100);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk("t1_valid", 32'(out_valid), 32'd1);
            chk("t1_pc", out_pc, START + 32'(4 * k));
            chk("t1_insn", out_insn, 32'h100 + 32'(k));
        end

        // 2: stall fills the queue, then drain
        run = 1'b0; out_ready = 1'b0;
        tick();
        run = 1'b1;
        for (int k = 0; k < 20 && q_count != 3'(QD); k++) tick();
        chk("t2_full", 32'(q_count), 32'(QD));
        for (int k = 0; k < 3; k++) tick();
        chk("t2_hold", 32'(q_count), 32'(QD));
        chk("t2_head_pc", out_pc, START);
        chk("t2_head_insn", out_insn, 32'h100);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t2_no_gap", 32'(out_valid), 32'd1);
        end

        // 3: redirect with a full queue
        out_ready = 1'b0;
        for (int k = 0; k < 20 && q_count != 3'(QD); k++) tick();
        chk("t3_full", 32'(q_count), 32'(QD));
        pc_in = 32'h8000_0010; pc_in_en = 1'b1;
        tick();
        pc_in_en = 1'b0;
        chk("t3_flush_valid", 32'(out_valid), 32'd0);
        chk("t3_flush_count", 32'(q_count), 32'd0);
        tick();
        chk("t3_gap_valid", 32'(out_valid), 32'd0);
        tick();
        chk("t3_valid", 32'(out_valid), 32'd1);
        chk("t3_pc", out_pc, 32'h8000_0010);
        chk("t3_insn", out_insn, 32'h104);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) tick();

        // 4: redirect coincides with a pop
        run = 1'b0; out_ready = 1'b0;
        tick();
        run = 1'b1;
        for (int k = 0; k < 10 && !out_valid; k++) tick();
        chk("t4_start", out_pc, START);
        out_ready = 1'b1;
        tick();
        chk("t4_head", out_pc, START + 32'd4);
        pops0 = n_pops;
        pc_in = 32'h8000_0040; pc_in_en = 1'b1;
        tick();
        pc_in_en = 1'b0;
        tick();
        tick();
        chk("t4_pop_once", 32'(n_pops - pops0), 32'd1);
        chk("t4_valid", 32'(out_valid), 32'd1);
        chk("t4_pc", out_pc, 32'h8000_0040);
        chk("t4_insn", out_insn, model_mem[16]);

        // 5: run drop, host write, restart
        for (int k = 0; k < 4; k++) tick();
        run = 1'b0;
        insn_we = 1'b1; insn_addr = START + 32'd8; insn_din = 32'hDEAD;
        model_mem[2] = 32'hDEAD;
        tick();
        insn_we = 1'b0;
        tick();
        run = 1'b1;
        tick();
        tick();
        chk("t5_restart_pc", out_pc, START);
        tick();
        tick();
        chk("t5_third_pc", out_pc, START + 32'd8);
        chk("t5_third_insn", out_insn, 32'hDEAD);

        // 6: asynchronous reset mid-stream
        for (int k = 0; k < 5; k++) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_count", 32'(q_count), 32'd0);
        chk("t6_pc", out_pc, 32'd0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 6 && !out_valid; k++) tick();
        chk("t6_refetch_valid", 32'(out_valid), 32'd1);
        chk("t6_refetch_pc", out_pc, START);
        chk("t6_refetch_insn", out_insn, model_mem[0]);

        // Random traffic: stalls, redirects (incl. unaligned and wrapping), run drops with loads
        pops0 = n_pops;
        for (int c = 0; c < 3000; c++) begin
            int r;
            out_ready = ($urandom_range(0, 3) != 0);
            run = 1'b1; pc_in_en = 1'b0; insn_we = 1'b0;
            r = $urandom_range(0, 99);
            if (r < 5) begin
                case ($urandom_range(0, 3))
                    0: a = START + {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
                    1: a = START + {18'd0, 12'($urandom_range(0, 4095)), 2'b00}
                           + 32'($urandom_range(1, 3));
                    2: a = 32'hFFFF_FFF0;
                    default: a = $urandom;
                endcase
                pc_in = a; pc_in_en = 1'b1;
                tick();
            end else if (r < 7) begin
                int n = $urandom_range(1, 3);
                for (int j = 0; j < n; j++) begin
                    run = 1'b0;
                    insn_we = ($urandom_range(0, 1) == 1);
                    a = $urandom; d = $urandom;
                    insn_addr = a; insn_din = d;
                    if (insn_we) model_mem[a[AW+1:2]] = d;
                    tick();
                end
                insn_we = 1'b0;
            end else begin
                tick();
            end
        end
        run = 1'b1; pc_in_en = 1'b0; insn_we = 1'b0;
        n_tests++;
        if (n_pops - pops0 < 500) begin
            n_fail++;
            $display("FAIL rand_throughput: got %0d pops required at least 500", n_pops - pops0);
        end
        run = 1'b0;
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
